// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-master round-robin arbiter and sequencer in front of the single-port
//   on-chip RAM (1-cycle synchronous read) and the byte-wide output register.
//   One transaction at a time: IDLE (arbitrate) -> ACCESS (strobe) -> RESP (ready).
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   mX_valid/addr/wdata/wstrb  master X request, held until mX_ready
//   mX_ready, mX_rdata      one-cycle completion pulse and read data
//   mem_en/we/addr/wdata    RAM port, mem_rdata returns the cycle after mem_en
//   io_wen, io_wdata        byte-register write pulse and data
//   err                     one-cycle pulse on a decode miss (with ready)
module mem_port_arbiter #(
  parameter int          MEM_SIZE  = 4096,
  parameter logic [31:0] MMIO_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        io_wen,
  output logic [7:0]  io_wdata,
  output logic        err
);

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   grant;       // 0 = m0 owns the current transaction, 1 = m1
  logic   last_grant;  // master served by the previous transaction
  logic   rd_mem;      // current transaction is a RAM read
  logic   miss;        // current transaction decodes to nothing

  logic        any_req;
  logic        win;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstrb;
  logic        win_mem;
  logic        win_io;

  // Arbitration and decode of the request that would be granted this cycle.
  // Decoding at grant time lets every ACCESS strobe come straight from a flop.
  always_comb begin
    any_req   = m0_valid | m1_valid;
    win       = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_wstrb = win ? m1_wstrb : m0_wstrb;
    win_mem   = {2'b00, win_addr[31:2]} < MEM_WORDS;
    win_io    = (win_addr == MMIO_ADDR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rd_mem     <= 1'b0;
      miss       <= 1'b0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 4'b0;
      mem_addr   <= 12'b0;
      mem_wdata  <= 32'b0;
      io_wen     <= 1'b0;
      io_wdata   <= 8'b0;
      err        <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 4'b0;
      io_wen   <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= ACCESS;
            grant  <= win;
            rd_mem <= win_mem && (win_wstrb == 4'b0);
            miss   <= !win_mem && !win_io;
            if (win_mem) begin
              mem_en    <= 1'b1;
              mem_we    <= win_wstrb;
              mem_addr  <= win_addr[13:2];
              mem_wdata <= win_wdata;
            end else if (win_io && (win_wstrb != 4'b0)) begin
              io_wen   <= 1'b1;
              io_wdata <= win_wdata[7:0];
            end
          end
        end
        ACCESS: begin
          state    <= RESP;
          m0_ready <= !grant;
          m1_ready <= grant;
          err      <= miss;
        end
        RESP: begin
          // Returning to IDLE for one cycle means a valid still held after
          // ready is not sampled again as the same request.
          state      <= IDLE;
          last_grant <= grant;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read data arrives during RESP, so it is steered combinationally to
  // the granted master; everything else returns zero.
  always_comb begin
    m0_rdata = 32'b0;
    m1_rdata = 32'b0;
    if ((state == RESP) && rd_mem) begin
      if (grant) m1_rdata = mem_rdata;
      else       m0_rdata = mem_rdata;
    end
  end

endmodule
